// File: rtl/mesh_term_mux.sv
// mesh_term_mux: merges NCH source channels, each buffered by its own FIFO,
// into a single mesh-router terminal port. An arbiter moves one packet at a
// time into an output holding register that is handed to the router with a
// pndng/pop handshake. Destination IDs are checked against the mesh size and
// drops, destination errors and delivered broadcasts are counted.
module mesh_term_mux #(
  parameter int         ROWS       = 4,
  parameter int         COLUMS     = 4,
  parameter int         pckg_sz    = 32,
  parameter int         fifo_depth = 4,
  parameter logic [7:0] bdcst      = 8'hFF,
  parameter int         NCH        = 4,
  parameter int         ARB_MODE   = 0,
  parameter int         CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCH-1:0]         push,
  input  logic [NCH*pckg_sz-1:0] data_in,
  output logic [NCH-1:0]         full,
  output logic                   pndng,
  output logic [pckg_sz-1:0]     data_out,
  output logic [$clog2(NCH)-1:0] src_id,
  input  logic                   pop,
  input  logic                   clr_cnt,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic [CNT_W-1:0]       err_cnt,
  output logic [CNT_W-1:0]       bcst_cnt
);

  localparam int SID_W = $clog2(NCH);
  localparam int PTR_W = $clog2(fifo_depth);
  localparam int OCC_W = $clog2(fifo_depth + 1);
  localparam int INC_W = $clog2(NCH + 1);

  // A destination is accepted if it is the broadcast ID or lies inside the mesh.
  function automatic logic dest_ok(input logic [7:0] dest);
    return (dest == bdcst) ||
           ((int'(dest[7:4]) < ROWS) && (int'(dest[3:0]) < COLUMS));
  endfunction

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [INC_W-1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + (CNT_W+1)'(inc);
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  // Number of set bits, used to add several same-cycle events at once.
  function automatic logic [INC_W-1:0] ones(input logic [NCH-1:0] v);
    logic [INC_W-1:0] n;
    n = '0;
    for (int i = 0; i < NCH; i++) n = n + INC_W'(v[i]);
    return n;
  endfunction

  // Pointer advance with wrap at fifo_depth (depth need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(fifo_depth - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  logic [pckg_sz-1:0] mem    [NCH][fifo_depth];
  logic [PTR_W-1:0]   rd_ptr [NCH];
  logic [PTR_W-1:0]   wr_ptr [NCH];
  logic [OCC_W-1:0]   occ    [NCH];

  logic [NCH-1:0]     nonempty;
  logic [NCH-1:0]     dest_vld;
  logic [NCH-1:0]     wr_en;
  logic [NCH-1:0]     rd_en;
  logic [SID_W-1:0]   rr_ptr;
  logic [SID_W-1:0]   win;
  logic               any_cand;
  logic               load_ok;
  logic               load;
  logic [pckg_sz-1:0] head_data;
  logic [INC_W-1:0]   drop_inc;
  logic [INC_W-1:0]   err_inc;
  logic               bcst_inc;

  // Per-channel status and write qualification from the registered occupancy.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      full[i]     = (occ[i] == OCC_W'(fifo_depth));
      nonempty[i] = (occ[i] != '0);
      dest_vld[i] = dest_ok(data_in[i*pckg_sz + pckg_sz - 8 +: 8]);
      wr_en[i]    = push[i] && !full[i] && dest_vld[i];
    end
  end

  assign drop_inc = ones(push & full);
  assign err_inc  = ones(push & ~full & ~dest_vld);
  assign bcst_inc = pndng && pop && (data_out[pckg_sz-1 -: 8] == bdcst);

  // Arbiter: round-robin scan starting after rr_ptr, or lowest index first.
  always_comb begin
    int idx;
    idx      = 0;
    win      = '0;
    any_cand = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (ARB_MODE == 0) idx = (int'(rr_ptr) + 1 + k) % NCH;
      else               idx = k;
      if (!any_cand && nonempty[idx]) begin
        win      = SID_W'(idx);
        any_cand = 1'b1;
      end
    end
  end

  assign load_ok   = !pndng || pop;
  assign load      = load_ok && any_cand;
  assign head_data = mem[win][rd_ptr[win]];

  // Dequeue strobe goes only to the winning channel.
  always_comb begin
    for (int i = 0; i < NCH; i++) rd_en[i] = load && (win == SID_W'(i));
  end

  // FIFO pointers and occupancy; a full FIFO never writes, so no same-edge overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        occ[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (wr_en[i]) wr_ptr[i] <= ptr_inc(wr_ptr[i]);
        if (rd_en[i]) rd_ptr[i] <= ptr_inc(rd_ptr[i]);
        occ[i] <= occ[i] + OCC_W'(wr_en[i]) - OCC_W'(rd_en[i]);
      end
    end
  end

  // FIFO storage: data only, emptiness is tracked by occupancy so no reset needed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (wr_en[i]) mem[i][wr_ptr[i]] <= data_in[i*pckg_sz +: pckg_sz];
    end
  end

  // Output holding register; data_out/src_id keep their last value when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pndng    <= 1'b0;
      data_out <= '0;
      src_id   <= '0;
      rr_ptr   <= SID_W'(NCH - 1);
    end else if (load_ok) begin
      if (any_cand) begin
        pndng    <= 1'b1;
        data_out <= head_data;
        src_id   <= win;
        rr_ptr   <= win;
      end else begin
        pndng    <= 1'b0;
      end
    end
  end

  // Statistic counters; clear wins over same-cycle increments.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt <= '0;
      err_cnt  <= '0;
      bcst_cnt <= '0;
    end else if (clr_cnt) begin
      drop_cnt <= '0;
      err_cnt  <= '0;
      bcst_cnt <= '0;
    end else begin
      drop_cnt <= sat_add(drop_cnt, drop_inc);
      err_cnt  <= sat_add(err_cnt, err_inc);
      bcst_cnt <= sat_add(bcst_cnt, INC_W'(bcst_inc));
    end
  end

endmodule

// File: tb/tb_mesh_term_mux.sv
// Bench for mesh_term_mux: a round-robin and a fixed-priority instance share
// one stimulus stream; a queue-based reference model predicts each packet the
// output register must present, and a monitor compares on the falling edge.
module tb_mesh_term_mux;
  localparam int NCH   = 4;
  localparam int PW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic              clk     = 1'b0;
  logic              reset   = 1'b1;
  logic [NCH-1:0]    push    = '0;
  logic [NCH*PW-1:0] data_in = '0;
  logic              pop     = 1'b0;
  logic              clr_cnt = 1'b0;

  logic [NCH-1:0] full_w [2];
  logic [1:0]     pndng_w;
  logic [PW-1:0]  dout_w [2];
  logic [1:0]     src_w  [2];
  logic [CW-1:0]  drop_w [2];
  logic [CW-1:0]  err_w  [2];
  logic [CW-1:0]  bcst_w [2];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mesh_term_mux #(
      .ROWS(4), .COLUMS(4), .pckg_sz(PW), .fifo_depth(DEPTH), .bdcst(8'hFF),
      .NCH(NCH), .ARB_MODE(g), .CNT_W(CW)
    ) u_dut (
      .clk(clk), .reset(reset), .push(push), .data_in(data_in),
      .full(full_w[g]), .pndng(pndng_w[g]), .data_out(dout_w[g]),
      .src_id(src_w[g]), .pop(pop), .clr_cnt(clr_cnt),
      .drop_cnt(drop_w[g]), .err_cnt(err_w[g]), .bcst_cnt(bcst_w[g])
    );
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (index 0 = round-robin, 1 = fixed) ----
  typedef struct packed { logic [PW-1:0] d; logic [1:0] s; } exp_t;
  logic [PW-1:0] mq [2][NCH][$];
  exp_t          expq [2][$];
  bit            hold_v [2];
  logic [PW-1:0] hold_d [2];
  int            rr [2];
  int            m_drop [2];
  int            m_err [2];
  int            m_bcst [2];

  function automatic bit dest_valid(input logic [7:0] d);
    return (d == 8'hFF) || ((d[7:4] < 4'd4) && (d[3:0] < 4'd4));
  endfunction

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  function automatic logic [NCH-1:0] mfull(input int m);
    logic [NCH-1:0] r;
    for (int i = 0; i < NCH; i++) r[i] = (mq[m][i].size() == DEPTH);
    return r;
  endfunction

  task automatic model_clear();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < NCH; i++) mq[m][i].delete();
      expq[m].delete();
      hold_v[m] = 1'b0;
      hold_d[m] = '0;
      rr[m]     = NCH - 1;
      m_drop[m] = 0;
      m_err[m]  = 0;
      m_bcst[m] = 0;
    end
  endtask

  task automatic model_step(input int m);
    bit            was_full [NCH];
    int            win;
    logic [PW-1:0] d;
    for (int i = 0; i < NCH; i++) was_full[i] = (mq[m][i].size() == DEPTH);
    if (hold_v[m] && pop && hold_d[m][PW-1 -: 8] == 8'hFF) m_bcst[m] = sat(m_bcst[m] + 1);
    if (!hold_v[m] || pop) begin
      win = -1;
      for (int k = 0; k < NCH; k++) begin
        int c;
        c = (m == 0) ? (rr[m] + 1 + k) % NCH : k;
        if (win < 0 && mq[m][c].size() > 0) win = c;
      end
      if (win >= 0) begin
        hold_d[m] = mq[m][win].pop_front();
        hold_v[m] = 1'b1;
        if (m == 0) rr[m] = win;
        expq[m].push_back('{d: hold_d[m], s: 2'(win)});
      end else begin
        hold_v[m] = 1'b0;
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (push[i]) begin
        d = data_in[i*PW +: PW];
        if (was_full[i])              m_drop[m] = sat(m_drop[m] + 1);
        else if (!dest_valid(d[31:24])) m_err[m] = sat(m_err[m] + 1);
        else                          mq[m][i].push_back(d);
      end
    end
    if (clr_cnt) begin
      m_drop[m] = 0;
      m_err[m]  = 0;
      m_bcst[m] = 0;
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      for (int m = 0; m < 2; m++) model_step(m);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("pndng_m%0d", m), 64'(pndng_w[m]), 64'(hold_v[m]));
        if (hold_v[m] && pndng_w[m] && expq[m].size() > 0) begin
          e = expq[m][0];
          chk($sformatf("data_m%0d", m), 64'(dout_w[m]), 64'(e.d));
          chk($sformatf("src_m%0d", m), 64'(src_w[m]), 64'(e.s));
        end
        if (hold_v[m] && pop && expq[m].size() > 0) e = expq[m].pop_front();
        chk($sformatf("full_m%0d", m), 64'(full_w[m]), 64'(mfull(m)));
        chk($sformatf("drop_m%0d", m), 64'(drop_w[m]), 64'(m_drop[m]));
        chk($sformatf("err_m%0d", m), 64'(err_w[m]), 64'(m_err[m]));
        chk($sformatf("bcst_m%0d", m), 64'(bcst_w[m]), 64'(m_bcst[m]));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic [NCH-1:0] p, input logic [NCH*PW-1:0] d,
                      input logic pp, input logic cc);
    push    = p;
    data_in = d;
    pop     = pp;
    clr_cnt = cc;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    push    = '0;
    pop     = 1'b0;
    clr_cnt = 1'b0;
    reset   = 1'b0;
    model_clear();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  function automatic logic [PW-1:0] rand_pkt();
    logic [7:0] dst;
    int sel;
    sel = $urandom_range(0, 5);
    if (sel == 0)      dst = 8'hFF;
    else if (sel == 1) dst = {4'($urandom_range(4, 15)), 4'($urandom_range(0, 15))};
    else if (sel == 2) dst = {4'($urandom_range(0, 3)), 4'($urandom_range(4, 15))};
    else               dst = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
    return {dst, 24'($urandom)};
  endfunction

  int rr_seq [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int fp_seq [8] = '{0, 0, 1, 1, 2, 2, 3, 3};

  initial begin
    logic [NCH*PW-1:0] dv;
    logic [NCH*PW-1:0] dv_a;
    logic [NCH*PW-1:0] dv_b;

    for (int i = 0; i < NCH; i++) begin
      dv_a[i*PW +: PW] = {4'd0, 4'(i), 8'hA0, 16'(i)};
      dv_b[i*PW +: PW] = {4'd1, 4'(i), 8'hB0, 16'(i)};
    end

    // Test 1: reset state and basic path
    reset_dut();
    for (int m = 0; m < 2; m++) begin
      chk("t1_rst_pndng", 64'(pndng_w[m]), 64'd0);
      chk("t1_rst_full", 64'(full_w[m]), 64'd0);
      chk("t1_rst_data", 64'(dout_w[m]), 64'd0);
      chk("t1_rst_src", 64'(src_w[m]), 64'd0);
      chk("t1_rst_cnts", {16'd0, drop_w[m], err_w[m], bcst_w[m]}, 64'd0);
    end
    dv = '0;
    dv[0 +: PW] = 32'h0012ABCD;
    step(4'b0001, dv, 1'b0, 1'b0);
    chk("t1_pndng_at_write_edge", 64'(pndng_w[0]), 64'd0);
    step('0, '0, 1'b0, 1'b0);
    for (int m = 0; m < 2; m++) begin
      chk("t1_pndng", 64'(pndng_w[m]), 64'd1);
      chk("t1_data", 64'(dout_w[m]), 64'h0012ABCD);
      chk("t1_src", 64'(src_w[m]), 64'd0);
    end
    step('0, '0, 1'b1, 1'b0);
    chk("t1_pndng_after_pop", 64'(pndng_w[0]), 64'd0);

    // Test 2/3: round-robin vs fixed priority order
    reset_dut();
    step(4'hF, dv_a, 1'b0, 1'b0);
    step(4'hF, dv_b, 1'b0, 1'b0);
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("t2_rr_pndng%0d", j), 64'(pndng_w), 64'h3);
      chk($sformatf("t2_rr_src%0d", j), 64'(src_w[0]), 64'(rr_seq[j]));
      chk($sformatf("t3_fp_src%0d", j), 64'(src_w[1]), 64'(fp_seq[j]));
      step('0, '0, 1'b1, 1'b0);
    end
    chk("t2_drained", 64'(pndng_w), 64'd0);

    // Test 4: overflow with simultaneous dequeue
    reset_dut();
    for (int j = 0; j < 5; j++) begin
      dv = '0;
      dv[2*PW +: PW] = {8'h21, 24'(j)};
      step(4'b0100, dv, 1'b0, 1'b0);
    end
    for (int m = 0; m < 2; m++) chk("t4_full2", 64'(full_w[m]), 64'b0100);
    dv = '0;
    dv[2*PW +: PW] = {8'h21, 24'hDEAD};
    step(4'b0100, dv, 1'b1, 1'b0);
    for (int m = 0; m < 2; m++) chk("t4_drop", 64'(drop_w[m]), 64'd1);

    // Test 5: destination validation, broadcast, clear priority
    reset_dut();
    dv = '0;
    dv[1*PW +: PW] = 32'h45001111;
    step(4'b0010, dv, 1'b0, 1'b0);
    for (int m = 0; m < 2; m++) chk("t5_err", 64'(err_w[m]), 64'd1);
    step('0, '0, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    chk("t5_bad_not_presented", 64'(pndng_w), 64'd0);
    dv = '0;
    dv[3*PW +: PW] = 32'hFF00BC57;
    step(4'b1000, dv, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    for (int m = 0; m < 2; m++) begin
      chk("t5_bc_pndng", 64'(pndng_w[m]), 64'd1);
      chk("t5_bc_data", 64'(dout_w[m]), 64'hFF00BC57);
      chk("t5_bc_src", 64'(src_w[m]), 64'd3);
    end
    step('0, '0, 1'b1, 1'b0);
    for (int m = 0; m < 2; m++) chk("t5_bcst", 64'(bcst_w[m]), 64'd1);
    dv = '0;
    dv[0 +: PW] = 32'h45002222;
    step(4'b0001, dv, 1'b0, 1'b1);
    for (int m = 0; m < 2; m++)
      chk("t5_clr", {16'd0, drop_w[m], err_w[m], bcst_w[m]}, 64'd0);

    // Test 6: asynchronous reset mid-operation
    reset_dut();
    step(4'hF, dv_a, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) begin
      dv = '0;
      dv[1*PW +: PW] = {8'h13, 24'(j)};
      step(4'b0010, dv, 1'b0, 1'b0);
    end
    chk("t6_pre_pndng", 64'(pndng_w), 64'h3);
    chk("t6_pre_full", 64'(full_w[0]), 64'b0010);
    push = '0;
    #3;
    reset = 1'b0;
    model_clear();
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("t6_async_pndng", 64'(pndng_w[m]), 64'd0);
      chk("t6_async_full", 64'(full_w[m]), 64'd0);
    end
    #2;
    reset = 1'b1;
    @(posedge clk); #1;
    for (int j = 0; j < 10; j++) begin
      step('0, '0, 1'b1, 1'b0);
      chk($sformatf("t6_no_stale%0d", j), 64'(pndng_w), 64'd0);
    end

    // Randomized traffic: heavy backpressure, then near-full drain rate
    reset_dut();
    for (int c = 0; c < 900; c++) begin
      logic [NCH-1:0]    p;
      logic [NCH*PW-1:0] d;
      int                pp;
      pp = (c < 450) ? 50 : 90;
      for (int i = 0; i < NCH; i++) begin
        p[i] = ($urandom_range(0, 99) < 35);
        d[i*PW +: PW] = rand_pkt();
      end
      step(p, d, $urandom_range(0, 99) < pp, $urandom_range(0, 99) < 2);
    end
    for (int j = 0; j < 40; j++) step('0, '0, 1'b1, 1'b0);
    for (int m = 0; m < 2; m++) begin
      chk("rand_final_pndng", 64'(pndng_w[m]), 64'd0);
      chk("rand_final_full", 64'(full_w[m]), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
